// File: rtl/apb_sram_bridge.sv
// APB3/APB4 slave driving port 0 of a 1rw1r SRAM macro, with byte masking and read-latency wait states.
// Optional out-of-range decode with pslverr is enabled by defining APB_SRAM_ERR_EN.
module apb_sram_bridge #(
    parameter int unsigned  ADDR_W    = 8,
    parameter int unsigned  DATA_W    = 32,
    parameter int unsigned  READ_LAT  = 1,
    parameter logic [31:0]  BASE_ADDR = 32'h0000_0000,
    localparam int unsigned STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [STRB_W-1:0] sram_wmask,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int unsigned OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int unsigned HI_LSB = ADDR_W + OFF_W;
    localparam int unsigned CNT_W  = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        r_state;
    logic              r_write;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_prdata;
    logic              r_pready;
    logic              r_pslverr;
    logic              r_sram_csb;
    logic              r_sram_web;
    logic [STRB_W-1:0] r_sram_wmask;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_din;

    logic [1:0]        w_state_nxt;
    logic              w_write_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_prdata_nxt;
    logic              w_pready_nxt;
    logic              w_pslverr_nxt;
    logic              w_csb_nxt;
    logic              w_web_nxt;
    logic [STRB_W-1:0] w_wmask_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_din_nxt;

    logic              w_hit;
    logic [ADDR_W-1:0] w_word;
    logic              w_unused_paddr;

    assign w_word         = paddr[HI_LSB-1:OFF_W];
    // Byte-offset bits (and the upper bits when decode is off) are intentionally ignored
    assign w_unused_paddr = ^paddr;

`ifdef APB_SRAM_ERR_EN
    assign w_hit = (paddr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
`else
    assign w_hit = 1'b1;
`endif

    // Next-state and next-output logic; all outputs are registered from these values
    always_comb begin
        w_state_nxt   = r_state;
        w_write_nxt   = r_write;
        w_cnt_nxt     = r_cnt;
        w_prdata_nxt  = r_prdata;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_csb_nxt     = 1'b1;
        w_web_nxt     = 1'b1;
        w_wmask_nxt   = '0;
        w_addr_nxt    = r_sram_addr;
        w_din_nxt     = r_sram_din;

        case (r_state)
            S_IDLE: begin
                if (psel && !penable) begin
                    w_write_nxt = pwrite;
                    if (w_hit) begin
                        w_state_nxt = S_CMD;
                        w_csb_nxt   = 1'b0;
                        w_web_nxt   = !pwrite;
                        w_wmask_nxt = pwrite ? pstrb : {STRB_W{1'b1}};
                        w_addr_nxt  = w_word;
                        w_din_nxt   = pwdata;
                    end else begin
                        w_state_nxt   = S_RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                        if (!pwrite) begin
                            w_prdata_nxt = '0;
                        end
                    end
                end
            end
            S_CMD: begin
                if (!psel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_write) begin
                    w_state_nxt  = S_RESP;
                    w_pready_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_W'(READ_LAT);
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt  = S_RESP;
                    w_pready_nxt = 1'b1;
                    w_prdata_nxt = sram_dout;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_cnt        <= '0;
            r_prdata     <= '0;
            r_pready     <= 1'b0;
            r_pslverr    <= 1'b0;
            r_sram_csb   <= 1'b1;
            r_sram_web   <= 1'b1;
            r_sram_wmask <= '0;
            r_sram_addr  <= '0;
            r_sram_din   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_write      <= w_write_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prdata     <= w_prdata_nxt;
            r_pready     <= w_pready_nxt;
            r_pslverr    <= w_pslverr_nxt;
            r_sram_csb   <= w_csb_nxt;
            r_sram_web   <= w_web_nxt;
            r_sram_wmask <= w_wmask_nxt;
            r_sram_addr  <= w_addr_nxt;
            r_sram_din   <= w_din_nxt;
        end
    end

    assign prdata     = r_prdata;
    assign pready     = r_pready;
    assign pslverr    = r_pslverr;
    assign sram_csb   = r_sram_csb;
    assign sram_web   = r_sram_web;
    assign sram_wmask = r_sram_wmask;
    assign sram_addr  = r_sram_addr;
    assign sram_din   = r_sram_din;

endmodule

// File: doc/apb_sram_bridge.md
# apb_sram_bridge

APB3/APB4 slave that drives port 0 of a 1rw1r SRAM macro, replacing the tied-off macro instance at the SoC top. Decodes a configurable base address, converts each APB transfer into one macro command with byte masking, inserts wait states to cover the macro's read latency, and flags out-of-range accesses with `pslverr`. Parametrised in address depth, data width and read latency. The macro's read-only port 1 is not driven by this block and stays tied off at integration.

## Interface
- `ADDR_W`, 8: SRAM word-address width; depth is 2^ADDR_W words.
- `DATA_W`, 32: data width; must be a multiple of 8; `STRB_W = DATA_W/8`.
- `READ_LAT`, 1: cycles from the macro capture edge to valid `sram_dout`; range 1..4.
- `BASE_ADDR`, 32'h0000_0000: byte base of the window; aligned to `STRB_W << ADDR_W`.

Ports:
- `clk` in 1: single clock for APB and macro.
- `rst` in 1: reset, synchronous, active-high.
- `paddr` in 32: APB byte address.
- `psel` in 1: APB select.
- `penable` in 1: APB enable.
- `pwrite` in 1: 1 = write.
- `pwdata` in DATA_W: write data.
- `pstrb` in STRB_W: byte strobes.
- `prdata` out DATA_W: read data, registered.
- `pready` out 1: transfer complete, registered.
- `pslverr` out 1: error response, registered.
- `sram_csb` out 1: macro chip select, active-low.
- `sram_web` out 1: macro write enable, active-low.
- `sram_wmask` out STRB_W: macro byte mask.
- `sram_addr` out ADDR_W: macro word address.
- `sram_din` out DATA_W: macro write data.
- `sram_dout` in DATA_W: macro read data.

## Operation
- Decode: hit when `paddr[31:ADDR_W+log2(STRB_W)]` matches the same bits of `BASE_ADDR`. Word index is `paddr[ADDR_W+log2(STRB_W)-1:log2(STRB_W)]`. Low byte bits are ignored.
- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE: on `psel && !penable` (setup), register the address, `pwrite`, `pwdata` and `pstrb`.
  - Hit: go to CMD.
  - Miss: go to RESP with the error flag set.
- CMD: drive `sram_csb=0` and `sram_web=!pwrite_q`. `sram_wmask` is `pstrb_q` for writes and all-ones for reads. The macro captures on the next edge.
  - Write: go to RESP.
  - Read: go to WAIT and load a counter with `READ_LAT`.
- WAIT: `sram_csb=1`. Decrement the counter. When it reaches 1, capture `sram_dout` into `prdata` and go to RESP.
- RESP: `pready=1` for exactly one cycle. `pslverr` equals the error flag. Return to IDLE.
- A write with `pstrb=0` is still issued to the macro with `wmask=0`. It completes normally and memory is unchanged.
- `prdata` holds its last read value across writes and errors. An erroring read drives `prdata=0`.
- `psel` low in any non-IDLE state (protocol violation): abort to IDLE, `sram_csb=1`, no `pready`.
- `sram_csb` is low for exactly one cycle per hit transfer and never low for a miss.

## Timing
- Reset values: `prdata=0`, `pready=0`, `pslverr=0`, `sram_csb=1`, `sram_web=1`, `sram_wmask=0`, `sram_addr=0`, `sram_din=0`. FSM returns to IDLE.
- Setup cycle is S; access cycles are A1, A2, …
- Hit write: CMD in A1, `pready` in A2. One wait state.
- Hit read: CMD in A1, WAIT for A2..A(1+READ_LAT), `pready` with valid `prdata` in A(2+READ_LAT). With READ_LAT=1 that is A3.
- Miss: `pready=1` and `pslverr=1` in A1. Zero wait states.
- Back-to-back: a setup cycle may immediately follow the RESP cycle. Sustained rate is one write per 3 cycles.
- `rst` asserted mid-transfer: all outputs take reset values on the next edge. A macro write already captured may complete; the APB master must restart.

## Configuration
- `APB_SRAM_ERR_EN` defined:
  - Out-of-range decode is active.
  - Misses return `pslverr=1` with no macro access.
- `APB_SRAM_ERR_EN` undefined:
  - `pslverr` is tied 0.
  - All addresses hit; the word index aliases modulo 2^ADDR_W and upper address bits are ignored.

## Test plan
- Reset with `rst=1` for 2 cycles -> all outputs at reset values; `sram_csb` stays 1 with no traffic.
- Write 32'hDEAD_BEEF to BASE+0x10, `pstrb=4'hF`, then read the same address -> write `pready` in A2 with `sram_addr=4`; read returns 32'hDEAD_BEEF with `pready` in A3, `pslverr=0`.
- Write 32'h1122_3344 with `pstrb=4'b0101` over 32'hFFFF_FFFF, then read -> 32'hFF22_FF44; `sram_wmask=4'b0101` seen during CMD.
- Access BASE+0x400 with ADDR_W=8 and `APB_SRAM_ERR_EN` defined -> `pready=1` and `pslverr=1` in A1, `sram_csb` never low. With the macro undefined -> the access aliases to word 0 and `pslverr=0`.
- READ_LAT=3 read -> `pready` in A5, and `prdata` equals the model's `sram_dout` from the final WAIT cycle.
- `rst` asserted in the WAIT cycle of a read -> no `pready`, `prdata=0`; the next transfer completes normally.
